// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage <-> multiply/divide unit bundle.
//   master : EX stage side. It drives start/op/src_a/src_b/annul/ex_advance
//            and receives stallreq/result_valid/hi_o/lo_o/div_by_zero.
//   slave  : the multiply/divide unit, with the opposite directions.
//   WIDTH  : operand and result width.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             annul;
  logic             ex_advance;
  logic             stallreq;
  logic             result_valid;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             div_by_zero;

  modport master (
    output start, op, src_a, src_b, annul, ex_advance,
    input  stallreq, result_valid, hi_o, lo_o, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, annul, ex_advance,
    output stallreq, result_valid, hi_o, lo_o, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit for the EX stage.
//   op 00 mult, 01 multu, 10 div, 11 divu. Multiplies take MUL_LAT cycles
//   through a product register pipeline. Divides run radix-2 restoring on
//   operand magnitudes, one quotient bit per cycle, with sign fix-up
//   applied as the result is written.
//   Results sit in hi_o/lo_o (mul: product high/low, div: remainder/quotient)
//   until the EX stage advances. annul aborts any operation.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  muldiv_if.slave: start, op, src_a, src_b, annul, ex_advance in;
//        stallreq, result_valid, hi_o, lo_o, div_by_zero out
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2((WIDTH > MUL_LAT) ? WIDTH : MUL_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             b_zero;
  logic             ld_mul;
  logic             ld_div;
  logic             ld_dbz;
  logic             stall;

  logic [1:0]              op_p0;
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0]        dvs_p0;

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod_p0;
  logic signed [2*WIDTH-1:0] prod_tap;

  logic [WIDTH-1:0] rem_p1;
  logic [WIDTH-1:0] quo_p1;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             dbz_r;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  // Control decode
  always_comb begin
    b_zero = (bus.src_b == '0);
    accept = (state == S_IDLE) && bus.start && !bus.annul;
    ld_dbz = accept && bus.op[1] && b_zero;
    ld_mul = (state == S_MUL) && (cnt == '0) && !bus.annul;
    ld_div = (state == S_DIV) && (cnt == '0) && !bus.annul;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!bus.op[1]) begin
            state_nx = S_MUL;
          end else if (b_zero) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_DIV;
          end
        end
      end
      S_MUL:   if (cnt == '0) state_nx = S_DONE;
      S_DIV:   if (cnt == '0) state_nx = S_DONE;
      S_DONE:  if (bus.ex_advance) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (bus.annul) begin
      state_nx = S_IDLE;
    end
  end

  // A divide by zero is resolved entirely at accept time, so it never stalls.
  always_comb begin
    stall = 1'b0;
    if (!bus.annul) begin
      case (state)
        S_IDLE:  stall = bus.start && !(bus.op[1] && b_zero);
        S_MUL:   stall = 1'b1;
        S_DIV:   stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.annul) begin
      cnt <= '0;
    end else if (accept) begin
      if (!bus.op[1]) begin
        cnt <= CNT_MUL;
      end else if (b_zero) begin
        cnt <= '0;
      end else begin
        cnt <= CNT_DIV;
      end
    end else if (((state == S_MUL) || (state == S_DIV)) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Stage p0: operands captured at accept; divider seeded with magnitudes
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= bus.op;
      a_p0   <= bus.src_a;
      b_p0   <= bus.src_b;
      dvs_p0 <= magnitude(bus.src_b, !bus.op[0]);
      quo_p1 <= magnitude(bus.src_a, !bus.op[0]);
      rem_p1 <= '0;
    end else if (state == S_DIV) begin
      rem_p1 <= rem_nx;
      quo_p1 <= quo_nx;
    end
  end

  always_comb begin
    if (op_p0[0]) begin
      a_ext = {{WIDTH{1'b0}}, a_p0};
      b_ext = {{WIDTH{1'b0}}, b_p0};
    end else begin
      a_ext = {{WIDTH{a_p0[WIDTH-1]}}, a_p0};
      b_ext = {{WIDTH{b_p0[WIDTH-1]}}, b_p0};
    end
    prod_p0 = a_ext * b_ext;
  end

  // Stage p1..: product register pipeline, advanced only while in MUL
  generate
    if (MUL_LAT == 1) begin : g_mul_comb
      assign prod_tap = prod_p0;
    end else begin : g_mul_pipe
      logic signed [2*WIDTH-1:0] prod_p1 [MUL_LAT-1];

      always_ff @(posedge clk) begin
        if (state == S_MUL) begin
          prod_p1[0] <= prod_p0;
          for (int k = 1; k < MUL_LAT - 1; k++) begin
            prod_p1[k] <= prod_p1[k-1];
          end
        end
      end

      assign prod_tap = prod_p1[MUL_LAT-2];
    end
  endgenerate

  // Stage p1: one restoring-division step; the remainder shifts in the next
  // dividend bit and the trial subtraction decides the quotient bit.
  always_comb begin
    rem_sh = {rem_p1, quo_p1[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_p0};
    if (!diff[WIDTH]) begin
      rem_nx = diff[WIDTH-1:0];
      quo_nx = {quo_p1[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo_p1[WIDTH-2:0], 1'b0};
    end
    // Quotient truncates toward zero; remainder follows the dividend.
    // min / -1 falls out naturally: the magnitude quotient is already min.
    neg_q = !op_p0[0] && (a_p0[WIDTH-1] ^ b_p0[WIDTH-1]);
    neg_r = !op_p0[0] && a_p0[WIDTH-1];
  end

  // Result registers: written only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r  <= '0;
      lo_r  <= '0;
      dbz_r <= 1'b0;
    end else if (ld_dbz) begin
      hi_r  <= bus.src_a;
      lo_r  <= '1;
      dbz_r <= 1'b1;
    end else if (ld_mul) begin
      hi_r  <= prod_tap[2*WIDTH-1:WIDTH];
      lo_r  <= prod_tap[WIDTH-1:0];
      dbz_r <= 1'b0;
    end else if (ld_div) begin
      hi_r  <= sign_fix(rem_nx, neg_r);
      lo_r  <= sign_fix(quo_nx, neg_q);
      dbz_r <= 1'b0;
    end
  end

  assign bus.stallreq     = stall;
  assign bus.result_valid = (state == S_DONE);
  assign bus.hi_o         = hi_r;
  assign bus.lo_o         = lo_r;
  assign bus.div_by_zero  = dbz_r;

endmodule
